// File: rtl/div32_seq.sv
// div32_seq: iterative restoring divider for the MIPS DIV/DIVU path.
//
// Produces one quotient bit per clock by trial subtraction. An accepted start
// takes WIDTH CALC cycles plus one FIX cycle (33 cycles for WIDTH = 32); a zero
// divisor skips straight to FIX (1 cycle). Results are held until the next
// operation completes.
//
// Configuration macro: DIV_SIGNED_EN
//   defined   - 'sign' selects DIV (signed) or DIVU (unsigned)
//   undefined - 'sign' is ignored, every operation is DIVU, no negation logic
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   EN        output enable; 0 floats quotient, remainder and div_zero
//   start     request, sampled only in IDLE
//   sign      1 = signed divide, 0 = unsigned
//   dividend  numerator, latched on accepted start
//   divisor   denominator, latched on accepted start
//   busy      high while an operation is in flight
//   done      one-cycle pulse when results become valid
//   div_zero  last operation had a zero divisor
//   quotient  LO result
//   remainder HI result
module div32_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EN,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output wire              div_zero,
  output wire  [WIDTH-1:0] quotient,
  output wire  [WIDTH-1:0] remainder
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;   // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] dsr_q, dsr_d;   // divisor magnitude
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             divz_q, divz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remr_q, remr_d;

  logic [WIDTH-1:0] dvd_mag, dsr_mag;
  logic [WIDTH:0]   shift, trial;

`ifdef DIV_SIGNED_EN
  logic negq_q, negq_d;  // quotient must be negated in FIX
  logic negr_q, negr_d;  // remainder must be negated in FIX
  logic dvd_neg, dsr_neg;

  assign dvd_neg = sign & dividend[WIDTH-1];
  assign dsr_neg = sign & divisor[WIDTH-1];
  // 0x80000000 negates to itself, which is the correct magnitude as unsigned.
  assign dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
  assign dsr_mag = dsr_neg ? (~divisor + 1'b1) : divisor;
`else
  logic unused_sign;
  assign unused_sign = sign;
  assign dvd_mag     = dividend;
  assign dsr_mag     = divisor;
`endif

  // One restoring step: the extra top bit of the WIDTH+1-bit subtraction is the
  // borrow, so trial[WIDTH] = 1 means the trial went negative.
  assign shift = {rem_q, quo_q[WIDTH-1]};
  assign trial = shift - {1'b0, dsr_q};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    divz_d  = divz_q;
    quot_d  = quot_q;
    remr_d  = remr_q;
`ifdef DIV_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          busy_d = 1'b1;
          rem_d  = '0;
          cnt_d  = '0;
          dsr_d  = dsr_mag;
          if (divisor == '0) begin
            // Keep the raw dividend; it becomes the remainder in FIX.
            dz_d    = 1'b1;
            quo_d   = dividend;
            state_d = StFix;
          end else begin
            dz_d    = 1'b0;
            quo_d   = dvd_mag;
            state_d = StCalc;
          end
`ifdef DIV_SIGNED_EN
          negq_d = dvd_neg ^ dsr_neg;
          negr_d = dvd_neg;
`endif
        end
      end

      StCalc: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
        end else begin
          rem_d = shift[WIDTH-1:0];
        end
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end

      StFix: begin
        if (dz_q) begin
          quot_d = '1;
          remr_d = quo_q;
          divz_d = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
          quot_d = negq_q ? (~quo_q + 1'b1) : quo_q;
          remr_d = negr_q ? (~rem_q + 1'b1) : rem_q;
`else
          quot_d = quo_q;
          remr_d = rem_q;
`endif
          divz_d = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
      quot_q  <= '0;
      remr_q  <= '0;
`ifdef DIV_SIGNED_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      divz_q  <= divz_d;
      quot_q  <= quot_d;
      remr_q  <= remr_d;
`ifdef DIV_SIGNED_EN
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = EN ? divz_q : 1'bz;
  assign quotient  = EN ? quot_q : {WIDTH{1'bz}};
  assign remainder = EN ? remr_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: randomized and directed operations compared
// against an arithmetic reference model, plus handshake, reset and EN scenarios.
module tb_div32_seq;

`ifdef DIV_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        EN;
  logic        start;
  logic        sign;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  // Pulled-up nets so a floated output reads as all ones.
  tri1         div_zero;
  tri1  [31:0] quotient;
  tri1  [31:0] remainder;

  int total = 0;
  int bad   = 0;

  div32_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .EN        (EN),
    .start     (start),
    .sign      (sign),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain arithmetic, truncating toward zero for signed operands.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz, output int lat);
    int sa, sb;
    dz  = (b == 32'd0);
    lat = dz ? 1 : 33;
    if (dz) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s && SignedEn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Drive one start pulse; returns #1 after the accepting edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    dividend = a;
    divisor  = b;
    sign     = s;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen, bounded at 100.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; EN = 1'b1; start = 1'b0; sign = 1'b0;
    dividend = '0; divisor = '0;
    #3;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b want=0", div_zero); end
    total++; if (quotient !== 32'd0) begin bad++; $display("FAIL reset_q got=%h want=0", quotient); end
    total++; if (remainder !== 32'd0) begin bad++; $display("FAIL reset_r got=%h want=0", remainder); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic s);
    logic [31:0] q, r;
    logic        dz;
    int          lat, cyc;
    ref_div(a, b, s, q, r, dz, lat);
    start_op(a, b, s);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy got=%b want=1", name, busy); end
    wait_done(cyc);
    total++; if (cyc != lat) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, cyc, lat); end
    total++; if (quotient !== q) begin bad++; $display("FAIL %s_q got=%h want=%h", name, quotient, q); end
    total++; if (remainder !== r) begin bad++; $display("FAIL %s_r got=%h want=%h", name, remainder, r); end
    total++; if (div_zero !== dz) begin bad++; $display("FAIL %s_dz got=%b want=%b", name, div_zero, dz); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_done got=%b want=0", name, busy); end
    @(posedge clk);
    #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_done_pulse got=%b want=0", name, done); end
  endtask

  task automatic test_start_ignored;
    logic [31:0] q, r;
    logic        dz;
    int          lat, cyc;
    ref_div(32'd1000, 32'd7, 1'b0, q, r, dz, lat);
    start_op(32'd1000, 32'd7, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    start_op(32'd55, 32'd3, 1'b1);
    wait_done(cyc);
    total++; if (cyc + 10 != lat) begin bad++; $display("FAIL ignore_latency got=%0d want=%0d", cyc + 10, lat); end
    total++; if (quotient !== q) begin bad++; $display("FAIL ignore_q got=%h want=%h", quotient, q); end
    total++; if (remainder !== r) begin bad++; $display("FAIL ignore_r got=%h want=%h", remainder, r); end
    @(posedge clk);
    #1;
    // A re-latched second operation would still be busy here.
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_idle got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid;
    int cyc, pulses;
    start_op(32'h0000_5678, 32'd0, 1'b0);
    wait_done(cyc);
    total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL rmid_pre_dz got=%b want=1", div_zero); end
    start_op(32'hDEAD_BEEF, 32'd13, 1'b0);
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL rmid_dz got=%b want=0", div_zero); end
    total++; if (quotient !== 32'd0) begin bad++; $display("FAIL rmid_q got=%h want=0", quotient); end
    total++; if (remainder !== 32'd0) begin bad++; $display("FAIL rmid_r got=%h want=0", remainder); end
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL rmid_no_done got=%0d want=0", pulses); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] q1, r1, q2, r2;
    logic        dz1, dz2;
    int          lat1, lat2, cyc;
    ref_div(32'd12345, 32'd100, 1'b0, q1, r1, dz1, lat1);
    ref_div(32'hFFFF_FF00, 32'd3, 1'b1, q2, r2, dz2, lat2);
    start_op(32'd12345, 32'd100, 1'b0);
    wait_done(cyc);
    total++; if (quotient !== q1) begin bad++; $display("FAIL b2b_q1 got=%h want=%h", quotient, q1); end
    total++; if (remainder !== r1) begin bad++; $display("FAIL b2b_r1 got=%h want=%h", remainder, r1); end
    start_op(32'hFFFF_FF00, 32'd3, 1'b1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", busy); end
    wait_done(cyc);
    total++; if (cyc != lat2) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", cyc, lat2); end
    total++; if (quotient !== q2) begin bad++; $display("FAIL b2b_q2 got=%h want=%h", quotient, q2); end
    total++; if (remainder !== r2) begin bad++; $display("FAIL b2b_r2 got=%h want=%h", remainder, r2); end
  endtask

  task automatic test_en_gating;
    logic [31:0] q, r;
    logic        dz;
    int          lat, cyc;
    ref_div(32'd200, 32'd9, 1'b0, q, r, dz, lat);
    EN = 1'b0;
    start_op(32'd200, 32'd9, 1'b0);
    wait_done(cyc);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL en_done got=%b want=1", done); end
    total++; if (quotient !== 32'hFFFF_FFFF) begin bad++; $display("FAIL en_q_float got=%h want=ffffffff", quotient); end
    total++; if (remainder !== 32'hFFFF_FFFF) begin bad++; $display("FAIL en_r_float got=%h want=ffffffff", remainder); end
    total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL en_dz_float got=%b want=1", div_zero); end
    @(posedge clk);
    #1;
    EN = 1'b1;
    #1;
    total++; if (quotient !== q) begin bad++; $display("FAIL en_q got=%h want=%h", quotient, q); end
    total++; if (remainder !== r) begin bad++; $display("FAIL en_r got=%h want=%h", remainder, r); end
    total++; if (div_zero !== dz) begin bad++; $display("FAIL en_dz got=%b want=%b", div_zero, dz); end
  endtask

  task automatic test_random(input int n);
    logic [31:0] a, b, q, r;
    logic        s, dz;
    int          lat, cyc;
    for (int i = 0; i < n; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        3:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4:       b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      ref_div(a, b, s, q, r, dz, lat);
      start_op(a, b, s);
      wait_done(cyc);
      total++; if (cyc != lat) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, cyc, lat); end
      total++; if (quotient !== q) begin bad++; $display("FAIL rnd%0d_q a=%h b=%h s=%b got=%h want=%h", i, a, b, s, quotient, q); end
      total++; if (remainder !== r) begin bad++; $display("FAIL rnd%0d_r a=%h b=%h s=%b got=%h want=%h", i, a, b, s, remainder, r); end
      total++; if (div_zero !== dz) begin bad++; $display("FAIL rnd%0d_dz got=%b want=%b", i, div_zero, dz); end
    end
  endtask

  initial begin
    test_reset();
    test_directed("udiv_100_7", 32'd100, 32'd7, 1'b0);
    test_directed("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    test_directed("udiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0);
    test_directed("div_zero", 32'h0000_1234, 32'd0, 1'b1);
    test_directed("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    test_directed("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_en_gating();
    test_random(40);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
